// File: rtl/irq_vector_ctrl_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Nesting is enabled by defining IRQ_NEST_EN.
package irq_pkg;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_REQ
  } irq_state_e;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_00DB;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0033;

  localparam int MAX_SRC = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } lowest_t;

  // Scanning from the top leaves the lowest set index last.
  function automatic lowest_t lowest_set(
    input logic [MAX_SRC-1:0] v
  );
    lowest_t r;
    r = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = MAX_ID_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// CPU-facing interrupt request / acknowledge / return bundle.
// master = controller side, slave = CPU side.
interface irq_vector_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 2
);

  logic              irq_req;
  logic [ADDR_W-1:0] irq_addr;
  logic [ID_W-1:0]   irq_id;
  logic              irq_ack;
  logic              irq_ret;

  modport master (
    output irq_req,
    output irq_addr,
    output irq_id,
    input  irq_ack,
    input  irq_ret
  );

  modport slave (
    input  irq_req,
    input  irq_addr,
    input  irq_id,
    output irq_ack,
    output irq_ret
  );

endinterface

// File: rtl/irq_vector_ctrl_prio_enc.sv
// Fixed-priority encoder: index 0 wins.
// Returns the lowest set bit and a valid flag.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_SRC-1:0] ext;
  lowest_t            res;
  logic               unused_hi;

  always_comb begin
    ext = '0;
    ext[NUM_SRC-1:0] = vec;
    res = lowest_set(ext);
  end

  assign valid     = res.valid;
  assign idx       = res.idx[ID_W-1:0];
  assign unused_hi = ^res.idx;

endmodule

// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: edge latch, mask, fixed priority,
// in-service tracking. Nesting enabled by defining IRQ_NEST_EN.
module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter int                NUM_SRC    = 4,
  parameter int                ID_W       = $clog2(NUM_SRC),
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               ie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  irq_vector_if.master       irq,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] in_service_o
);

  irq_state_e state, state_nx;

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] edge_v;
  logic [NUM_SRC-1:0] ack_set;
  logic [NUM_SRC-1:0] ret_clr;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] vec_addr;

  logic            cand_vld;
  logic [ID_W-1:0] cand_id;
  logic            isv_vld;
  logic [ID_W-1:0] isv_id;
  logic            elig;
  logic            load;
  logic            take;

  assign edge_v = src_in & ~src_d;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_cand_enc (
    .vec   (pending & mask),
    .valid (cand_vld),
    .idx   (cand_id)
  );

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_isv_enc (
    .vec   (in_service),
    .valid (isv_vld),
    .idx   (isv_id)
  );

`ifdef IRQ_NEST_EN
  assign elig = ie & cand_vld
              & (~isv_vld | (cand_id < isv_id));
  assign ret_clr = (irq.irq_ret & isv_vld)
                 ? (NUM_SRC'(1) << isv_id)
                 : '0;
`else
  logic unused_isv;
  assign unused_isv = ^isv_id;
  assign elig = ie & cand_vld & ~isv_vld;
  assign ret_clr = irq.irq_ret ? in_service : '0;
`endif

  assign vec_addr = VEC_BASE
                  + ADDR_W'(cand_id) * VEC_STRIDE;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    take     = 1'b0;
    unique case (state)
      IRQ_IDLE: begin
        if (elig) begin
          state_nx = IRQ_REQ;
          load     = 1'b1;
        end
      end
      IRQ_REQ: begin
        // Ack wins over a simultaneous ie drop.
        if (irq.irq_ack) begin
          state_nx = IRQ_IDLE;
          take     = 1'b1;
        end else if (!ie) begin
          state_nx = IRQ_IDLE;
        end
      end
      default: state_nx = IRQ_IDLE;
    endcase
  end

  assign ack_set = take ? (NUM_SRC'(1) << id_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IRQ_IDLE;
      src_d      <= '0;
      pending    <= '0;
      mask       <= '1;
      in_service <= '0;
      id_q       <= '0;
      addr_q     <= '0;
    end else begin
      state      <= state_nx;
      src_d      <= src_in;
      pending    <= (pending & ~ack_set) | edge_v;
      in_service <= (in_service & ~ret_clr) | ack_set;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      if (load) begin
        id_q   <= cand_id;
        addr_q <= vec_addr;
      end
    end
  end

  assign irq.irq_req  = (state == IRQ_REQ);
  assign irq.irq_id   = id_q;
  assign irq.irq_addr = addr_q;
  assign pending_o    = pending;
  assign in_service_o = in_service;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl (default parameters).
// Expectations follow IRQ_NEST_EN when it is defined.
module tb_irq_vector_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] src_in;
  logic       ie;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] pending_o;
  logic [3:0] in_service_o;

  irq_vector_if #(.ADDR_W(32), .ID_W(2)) irq();

  irq_vector_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_in       (src_in),
    .ie           (ie),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .irq          (irq),
    .pending_o    (pending_o),
    .in_service_o (in_service_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic        ie;
    logic        mwe;
    logic [3:0]  mwd;
    logic        ack;
    logic        ret;
    logic        req;
    logic [1:0]  id;
    logic [31:0] addr;
    logic [3:0]  pend;
    logic [3:0]  isv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic void add(
    input logic [3:0] s, input logic i,
    input logic w, input logic [3:0] wd,
    input logic a, input logic r,
    input logic q, input logic [1:0] id,
    input logic [31:0] ad,
    input logic [3:0] p, input logic [3:0] is
  );
    vec_t v;
    v.src = s; v.ie = i; v.mwe = w; v.mwd = wd;
    v.ack = a; v.ret = r; v.req = q; v.id = id;
    v.addr = ad; v.pend = p; v.isv = is;
    tbl.push_back(v);
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered at a negedge; leaves at the next negedge.
  task automatic step(input vec_t v);
    vec_t e;
    string nm;
    src_in      = v.src;
    ie          = v.ie;
    mask_we     = v.mwe;
    mask_wdata  = v.mwd;
    irq.irq_ack = v.ack;
    irq.irq_ret = v.ret;
    sb.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e  = sb.pop_front();
      nm = $sformatf("s%0d", step_no);
      chk({nm, "_req"}, 32'(irq.irq_req), 32'(e.req));
      chk({nm, "_pend"}, 32'(pending_o), 32'(e.pend));
      chk({nm, "_isv"}, 32'(in_service_o), 32'(e.isv));
      if (e.req) begin
        chk({nm, "_id"}, 32'(irq.irq_id), 32'(e.id));
        chk({nm, "_addr"}, irq.irq_addr, e.addr);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t h;
    rst_n       = 1'b1;
    src_in      = '0;
    ie          = 1'b0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    irq.irq_ack = 1'b0;
    irq.irq_ret = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(irq.irq_req), 32'd0);
    chk("rst_addr", irq.irq_addr, 32'd0);
    chk("rst_id", 32'(irq.irq_id), 32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);
    chk("rst_isv", 32'(in_service_o), 32'd0);

    // src ie we wd ack ret | req id addr pend isv
    add(4'b0100,1,0,4'h0,0,0, 0,0,32'h0,     4'b0100,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,2,32'h0141,  4'b0100,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b0100);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);
    add(4'b1010,1,0,4'h0,0,0, 0,0,32'h0,     4'b1010,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,1,32'h010E,  4'b1010,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b1000,4'b0010);
    add(4'b0000,1,0,4'h0,0,0, 0,0,32'h0,     4'b1000,4'b0010);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b1000,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,3,32'h0174,  4'b1000,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b1000);
    add(4'b0001,1,0,4'h0,0,0, 0,0,32'h0,     4'b0001,4'b1000);
`ifdef IRQ_NEST_EN
    add(4'b0000,1,0,4'h0,0,0, 1,0,32'h00DB,  4'b0001,4'b1000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b1001);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b1000);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 0,0,32'h0,     4'b0000,4'b0000);
`else
    add(4'b0000,1,0,4'h0,0,0, 0,0,32'h0,     4'b0001,4'b1000);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0001,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,0,32'h00DB,  4'b0001,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b0001);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);
`endif
    add(4'b0100,1,1,4'hB,0,0, 0,0,32'h0,     4'b0100,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 0,0,32'h0,     4'b0100,4'b0000);
    add(4'b0000,1,1,4'hF,0,0, 0,0,32'h0,     4'b0100,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,2,32'h0141,  4'b0100,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b0100);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);
    add(4'b0010,1,0,4'h0,0,0, 0,0,32'h0,     4'b0010,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,1,32'h010E,  4'b0010,4'b0000);
    add(4'b0000,0,0,4'h0,0,0, 0,0,32'h0,     4'b0010,4'b0000);
    add(4'b0000,0,0,4'h0,0,0, 0,0,32'h0,     4'b0010,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,1,32'h010E,  4'b0010,4'b0000);
    add(4'b0000,0,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b0010);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);
    add(4'b0000,1,0,4'h0,1,0, 0,0,32'h0,     4'b0000,4'b0000);
    add(4'b0010,1,0,4'h0,0,0, 0,0,32'h0,     4'b0010,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,1,32'h010E,  4'b0010,4'b0000);
    add(4'b0010,1,0,4'h0,1,0, 0,0,32'h0,     4'b0010,4'b0010);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0010,4'b0000);
    add(4'b0000,1,0,4'h0,0,0, 1,1,32'h010E,  4'b0010,4'b0000);
    add(4'b0000,1,0,4'h0,1,1, 0,0,32'h0,     4'b0000,4'b0010);
    add(4'b0000,1,0,4'h0,0,1, 0,0,32'h0,     4'b0000,4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Source already high when reset releases: edge on first clock.
    rst_n  = 1'b0;
    src_in = 4'b0001;
    #1 rst_n = 1'b1;
    h = '{src:4'b0001, ie:1'b1, mwe:1'b0, mwd:4'h0,
          ack:1'b0, ret:1'b0, req:1'b0, id:2'd0,
          addr:32'h0, pend:4'b0001, isv:4'b0000};
    step(h);
    h.req  = 1'b1;
    h.addr = 32'h00DB;
    step(h);

    // Asynchronous reset in the middle of a request.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(irq.irq_req), 32'd0);
    chk("arst_addr", irq.irq_addr, 32'd0);
    chk("arst_pend", 32'(pending_o), 32'd0);
    chk("arst_isv", 32'(in_service_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
